// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Desc   : Shared CPU widths and write-back requester identifiers.
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_req_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter_if
// Desc   : Write-back request, decode scoreboard and register-file write bus.
// Rev    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_stall;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [NREG-1:0]   busy;

    // Pipeline / register-file side
    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        output issue_valid, issue_addr, rd_addr1, rd_addr2,
        input  rd_stall,
        input  wr_en, wr_addr, wr_data,
        input  fwd_valid, fwd_addr, fwd_data,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        input  issue_valid, issue_addr, rd_addr1, rd_addr2,
        output rd_stall,
        output wr_en, wr_addr, wr_data,
        output fwd_valid, fwd_addr, fwd_data,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : wb_scoreboard
// Desc   : Pending-write busy mask and decode operand stall with forward bypass.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              fwd_valid,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic [NREG-1:0]   busy,
    output logic              rd_stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            w_pend1;
    logic            w_pend2;

    // Set is applied after clear so a same-cycle issue keeps the bit high
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        w_pend1  = busy_q[rd_addr1] & ~(fwd_valid & (fwd_addr == rd_addr1));
        w_pend2  = busy_q[rd_addr2] & ~(fwd_valid & (fwd_addr == rd_addr2));
        rd_stall = reset & (w_pend1 | w_pend2);
    end

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter
// Desc   : Fixed-priority (load first) write-port arbiter with ALU starvation guard.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W       = cpu_pkg::DATA_W,
    parameter int ADDR_W       = cpu_pkg::ADDR_W,
    parameter int NREG         = cpu_pkg::NREG,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int              CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0]  starve_cnt_q;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic              wr_en_q;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] wr_data_d;

    logic              w_same_addr;
    logic              w_starved;
    logic              w_grant_alu;
    logic              w_grant_mem;
    logic              w_grant_any;
    wb_req_e           w_winner;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_data;

    // A same-address collision always goes to the older load
    always_comb begin
        w_same_addr = (bus.alu_addr == bus.mem_addr);
        w_starved   = (starve_cnt_q == C_STARVE_MAX);
        w_grant_alu = bus.alu_valid & (~bus.mem_valid | (w_starved & ~w_same_addr));
        w_grant_mem = bus.mem_valid & ~w_grant_alu;
        w_grant_any = w_grant_alu | w_grant_mem;
        w_winner    = w_grant_alu ? WB_ALU : WB_MEM;
    end

    always_comb begin
        w_grant_addr = bus.mem_addr;
        w_grant_data = bus.mem_data;
        case (w_winner)
            WB_ALU: begin
                w_grant_addr = bus.alu_addr;
                w_grant_data = bus.alu_data;
            end
            default: begin
                w_grant_addr = bus.mem_addr;
                w_grant_data = bus.mem_data;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.alu_valid || w_grant_alu) begin
            starve_cnt_d = '0;
        end else if (!w_starved) begin
            starve_cnt_d = starve_cnt_q + C_CNT_ONE;
        end
    end

    // Address and data hold their last value when no grant is made
    always_comb begin
        wr_en_d   = w_grant_any;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (w_grant_any) begin
            wr_addr_d = w_grant_addr;
            wr_data_d = w_grant_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign bus.alu_ready = reset & w_grant_alu;
    assign bus.mem_ready = reset & w_grant_mem;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.fwd_valid = wr_en_q;
    assign bus.fwd_addr  = wr_addr_q;
    assign bus.fwd_data  = wr_data_q;

    wb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .clr_en      (w_grant_any),
        .clr_addr    (w_grant_addr),
        .issue_valid (bus.issue_valid),
        .issue_addr  (bus.issue_addr),
        .rd_addr1    (bus.rd_addr1),
        .rd_addr2    (bus.rd_addr2),
        .fwd_valid   (wr_en_q),
        .fwd_addr    (wr_addr_q),
        .busy        (bus.busy),
        .rd_stall    (bus.rd_stall)
    );

endmodule
`default_nettype wire
